sram_controller: RTL

- Sequences the off-chip 16-bit SRAM on behalf of the Mem stage, replacing the single-cycle data memory.
- Splits each 32-bit word access into two 16-bit half accesses, each held for a parameterised number of wait cycles.
- Drives `ready` low while an access is in progress; top level forms `freeze = ~ready` and feeds it to the IF, ID and EXE stage registers so the pipeline stalls.

---
 rtl/mem_ctrl_defs.sv | 20 ++
 rtl/sram_controller.sv | 69 ++++++
 2 files changed

// File: rtl/mem_ctrl_defs.sv
// mem_ctrl_defs: shared state encoding, SRAM widths and default CPU base address
package mem_ctrl_defs;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 18;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_WR_LO = 3'd3;
  localparam logic [2:0] S_WR_HI = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    RD_LO = S_RD_LO,
    RD_HI = S_RD_HI,
    WR_LO = S_WR_LO,
    WR_HI = S_WR_HI,
    DONE  = S_DONE
  } state_t;
endpackage

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit Mem-stage accesses into two timed 16-bit SRAM half accesses
module sram_controller
  import mem_ctrl_defs::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          SRAM_ADDR_W = ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [DATA_W-1:0]      SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);
  state_t state, next;
  logic [3:0] cnt;
  logic last, rd, wr, hi;
  logic [31:0] off;
  logic unused_off;
  assign last = cnt == 4'(WAIT_CYCLES - 1);
  assign rd = state == RD_LO || state == RD_HI;
  assign wr = state == WR_LO || state == WR_HI;
  assign hi = state == RD_HI || state == WR_HI;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = wr_en ? WR_LO : rd_en ? RD_LO : IDLE;
      RD_LO:   next = last ? RD_HI : RD_LO;
      RD_HI:   next = last ? DONE : RD_HI;
      WR_LO:   next = last ? WR_HI : WR_LO;
      WR_HI:   next = last ? DONE : WR_HI;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
    end else begin
      state <= next;
      cnt   <= (next == state && (rd || wr)) ? cnt + 4'd1 : '0;
      if (state == RD_LO && last) read_data[15:0] <= SRAM_DQ;
      if (state == RD_HI && last) read_data[31:16] <= SRAM_DQ;
    end
  end
  // low address bits and anything beyond the SRAM window are deliberately dropped
  assign off = address - BASE_ADDR;
  assign unused_off = ^{off[31:SRAM_ADDR_W+1], off[1:0]};
  assign SRAM_ADDR = (rd || wr) ? {off[SRAM_ADDR_W:2], hi} : '0;
  assign SRAM_OE_N = !rd;
  // WE rises for the final cycle of each half so address/data never move under an active strobe
  assign SRAM_WE_N = !(wr && !last);
  assign SRAM_DQ = wr ? (hi ? write_data[31:16] : write_data[15:0]) : 'z;
  assign ready = state == DONE || (state == IDLE && !wr_en && !rd_en);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
endmodule
